// File: rtl/sramlike_axi_bridge_if.sv
// rtl/sramlike_axi_bridge_if.sv - sram-like data channel plus single-beat AXI4 bus bundle
//
// Purpose: bundles the cache-side sram-like request/response signals and the
// five AXI4 channels that sramlike_axi_bridge connects between.
// Modports:
//   master - the bridge. It answers the cache's data_* requests and is the AXI
//            master: it drives AR/AW/W and rready/bready.
//   slave  - the environment. This is the cache requester together with the
//            AXI slave that answers the bridge.
// Signals:
//   data_req/data_wr/data_size/data_addr/data_wdata  cache request
//   data_rdata/data_addr_ok/data_data_ok             cache response
//   ar*/r*/aw*/w*/b*                                 AXI4 channels (ID width ID_WIDTH)
interface sramlike_axi_bridge_if #(
    parameter int ID_WIDTH = 4
);
    logic                data_req;
    logic                data_wr;
    logic [1:0]          data_size;
    logic [31:0]         data_addr;
    logic [31:0]         data_wdata;
    logic [31:0]         data_rdata;
    logic                data_addr_ok;
    logic                data_data_ok;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sramlike_axi_bridge.sv
// rtl/sramlike_axi_bridge.sv - single-outstanding sram-like to single-beat AXI4 bridge
//
// Purpose: accepts one data-cache request at a time and issues it on AXI4 as
// a single-beat read (AR then R) or write (AW and W, then B). The cache sees
// data_data_ok as a one-cycle pulse when the transaction completes.
// Ports:
//   clk  - clock; all state changes on its rising edge
//   rst  - synchronous active-high reset
//   bus  - sramlike_axi_bridge_if.master. This carries the cache data_*
//          channel and the AXI AR/R/AW/W/B channels.
// Parameters:
//   ID_WIDTH - AXI ID width. It must match the width of the bus interface.
//   AXI_ID   - the constant ID driven on arid/awid/wid
module sramlike_axi_bridge #(
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    sramlike_axi_bridge_if.master     bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RADDR = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WADDR = 3'd3;
    localparam logic [2:0] S_WRESP = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_nxt;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done;
    logic        w_done;

    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic [2:0]  axsize;
    logic [3:0]  strb;

    // Requests are taken only in IDLE. rst is gated in so that a request
    // cannot be acknowledged while the bridge is being reset.
    assign accept = (state == S_IDLE) && bus.data_req && !rst;

    assign aw_hs = bus.awvalid && bus.awready;
    assign w_hs  = bus.wvalid  && bus.wready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = bus.data_wr ? S_WADDR : S_RADDR;
                end
            end
            S_RADDR: begin
                if (bus.arready) begin
                    state_nxt = S_RDATA;
                end
            end
            S_RDATA: begin
                if (bus.rvalid) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WADDR: begin
                // AW and W may complete in the same cycle or in either order.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bus.bvalid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wr_q    <= bus.data_wr;
                size_q  <= bus.data_size;
                addr_q  <= bus.data_addr;
                wdata_q <= bus.data_wdata;
            end
            // The flags accumulate only while the bridge stays in WADDR. They
            // are cleared on exit, so every write starts with both clear.
            if ((state == S_WADDR) && (state_nxt == S_WADDR)) begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done  || w_hs;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    // Size 11 is not a legal request size and is treated as a word.
    always_comb begin
        axsize = {1'b0, size_q};
        if (size_q == 2'b11) begin
            axsize = 3'b010;
        end
    end

    always_comb begin
        strb = 4'b1111;
        case (size_q)
            2'b00:   strb = 4'b0001 << addr_q[1:0];
            2'b01:   strb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // Cache side
    assign bus.data_addr_ok = accept;
    assign bus.data_rdata   = bus.rdata;
    assign bus.data_data_ok = !rst && (((state == S_RDATA) && bus.rvalid) ||
                                       ((state == S_WRESP) && bus.bvalid));

    // AR
    assign bus.arid    = ID_WIDTH'(AXI_ID);
    assign bus.araddr  = addr_q;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = axsize;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'b0000;
    assign bus.arprot  = 3'b000;
    assign bus.arvalid = (state == S_RADDR);

    // R
    assign bus.rready  = (state == S_RDATA);

    // AW
    assign bus.awid    = ID_WIDTH'(AXI_ID);
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = axsize;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'b00;
    assign bus.awcache = 4'b0000;
    assign bus.awprot  = 3'b000;
    assign bus.awvalid = (state == S_WADDR) && !aw_done;

    // W
    assign bus.wid     = ID_WIDTH'(AXI_ID);
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = strb;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = (state == S_WADDR) && !w_done;

    // B
    assign bus.bready  = (state == S_WRESP);

    // Response status, last flags and returned IDs are ignored. wr_q is kept
    // for visibility only, because the state already encodes the direction.
    logic unused_inputs;
    assign unused_inputs = ^{bus.rid, bus.rresp, bus.rlast, bus.bid, bus.bresp, wr_q};

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// tb/tb_sramlike_axi_bridge.sv - directed self-checking bench for sramlike_axi_bridge
module tb_sramlike_axi_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    sramlike_axi_bridge_if #(.ID_WIDTH(4)) bus ();

    sramlike_axi_bridge #(.ID_WIDTH(4), .AXI_ID(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Move to the next cycle. Inputs are driven 1ns after the edge, and checks
    // run after a further #1 so that combinational outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_req   = 1'b1;
        bus.data_wr    = wr;
        bus.data_size  = size;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
    endtask

    initial begin
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

        // Reset state
        tick(); tick();
        bus.data_req = 1'b1;
        settle();
        check("rst_addr_ok", 32'(bus.data_addr_ok), 0);
        check("rst_arvalid", 32'(bus.arvalid), 0);
        check("rst_awvalid", 32'(bus.awvalid), 0);
        check("rst_wvalid",  32'(bus.wvalid), 0);
        check("rst_rready",  32'(bus.rready), 0);
        check("rst_bready",  32'(bus.bready), 0);
        check("rst_data_ok", 32'(bus.data_data_ok), 0);
        tick();
        rst = 1'b0;
        bus.data_req = 1'b0;
        tick();

        // Word read, zero-wait slave
        req(1'b0, 2'b10, 32'h1FC0_0010, 32'h0);
        bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hDEADBEEF;
        settle();
        check("rd_c0_addr_ok", 32'(bus.data_addr_ok), 1);
        check("rd_c0_rready",  32'(bus.rready), 0);
        check("rd_c0_data_ok", 32'(bus.data_data_ok), 0);
        tick();
        bus.data_req = 0;
        settle();
        check("rd_c1_arvalid", 32'(bus.arvalid), 1);
        check("rd_c1_araddr",  bus.araddr, 32'h1FC0_0010);
        check("rd_c1_arsize",  32'(bus.arsize), 2);
        check("rd_c1_arlen",   32'(bus.arlen), 0);
        check("rd_c1_arburst", 32'(bus.arburst), 1);
        check("rd_c1_arid",    32'(bus.arid), 5);
        check("rd_c1_addr_ok", 32'(bus.data_addr_ok), 0);
        tick();
        settle();
        check("rd_c2_rready",  32'(bus.rready), 1);
        check("rd_c2_data_ok", 32'(bus.data_data_ok), 1);
        check("rd_c2_rdata",   bus.data_rdata, 32'hDEADBEEF);
        tick();
        bus.arready = 0; bus.rvalid = 0;
        settle();
        check("rd_c3_data_ok", 32'(bus.data_data_ok), 0);
        check("rd_c3_arvalid", 32'(bus.arvalid), 0);

        // Byte write: W accepted at c1, AW accepted at c3
        tick();
        req(1'b1, 2'b00, 32'h8000_0003, 32'hAB00_0000);
        settle();
        check("bw_c0_addr_ok", 32'(bus.data_addr_ok), 1);
        tick();
        bus.data_req = 0; bus.wready = 1;
        settle();
        check("bw_c1_awvalid", 32'(bus.awvalid), 1);
        check("bw_c1_wvalid",  32'(bus.wvalid), 1);
        check("bw_c1_wstrb",   32'(bus.wstrb), 32'b1000);
        check("bw_c1_awsize",  32'(bus.awsize), 0);
        check("bw_c1_wlast",   32'(bus.wlast), 1);
        check("bw_c1_wdata",   bus.wdata, 32'hAB00_0000);
        check("bw_c1_awaddr",  bus.awaddr, 32'h8000_0003);
        check("bw_c1_awid",    32'(bus.awid), 5);
        tick();
        bus.wready = 0;
        settle();
        check("bw_c2_wvalid",  32'(bus.wvalid), 0);
        check("bw_c2_awvalid", 32'(bus.awvalid), 1);
        check("bw_c2_bready",  32'(bus.bready), 0);
        tick();
        bus.awready = 1;
        settle();
        check("bw_c3_awvalid", 32'(bus.awvalid), 1);
        check("bw_c3_bready",  32'(bus.bready), 0);
        tick();
        bus.awready = 0;
        settle();
        check("bw_c4_awvalid", 32'(bus.awvalid), 0);
        check("bw_c4_bready",  32'(bus.bready), 1);
        check("bw_c4_data_ok", 32'(bus.data_data_ok), 0);
        tick();
        bus.bvalid = 1;
        settle();
        check("bw_c5_data_ok", 32'(bus.data_data_ok), 1);
        tick();
        bus.bvalid = 0;
        settle();
        check("bw_c6_bready",  32'(bus.bready), 0);
        check("bw_c6_data_ok", 32'(bus.data_data_ok), 0);

        // Half write at ...10, both handshakes in the same cycle, early bvalid
        req(1'b1, 2'b01, 32'h0000_1002, 32'h5A5A_0000);
        bus.awready = 1; bus.wready = 1; bus.bvalid = 1;
        settle();
        check("hw_c0_addr_ok", 32'(bus.data_addr_ok), 1);
        check("hw_c0_bready",  32'(bus.bready), 0);
        tick();
        bus.data_req = 0;
        settle();
        check("hw_c1_wstrb",   32'(bus.wstrb), 32'b1100);
        check("hw_c1_awsize",  32'(bus.awsize), 1);
        check("hw_c1_data_ok", 32'(bus.data_data_ok), 0);
        tick();
        settle();
        check("hw_c2_bready",  32'(bus.bready), 1);
        check("hw_c2_data_ok", 32'(bus.data_data_ok), 1);
        tick();
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;

        // Size 11 read, rvalid late while data_req stays high
        req(1'b0, 2'b11, 32'h0000_0100, 32'h0);
        bus.arready = 1;
        settle();
        check("s3_c0_addr_ok", 32'(bus.data_addr_ok), 1);
        tick();
        settle();
        check("s3_c1_arsize",  32'(bus.arsize), 2);
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            check("hold_rready",  32'(bus.rready), 1);
            check("hold_addr_ok", 32'(bus.data_addr_ok), 0);
            check("hold_arvalid", 32'(bus.arvalid), 0);
            tick();
        end
        bus.rvalid = 1; bus.rdata = 32'h1234_5678;
        settle();
        check("hold_data_ok",  32'(bus.data_data_ok), 1);
        check("hold_rdata",    bus.data_rdata, 32'h1234_5678);
        check("hold_ok_pulse", 32'(bus.data_addr_ok), 0);
        tick();
        bus.rvalid = 0;
        settle();
        check("hold_re_accept", 32'(bus.data_addr_ok), 1);
        tick();
        bus.data_req = 0;
        settle();
        check("hold_2nd_arvalid", 32'(bus.arvalid), 1);
        tick();
        bus.rvalid = 1; bus.rdata = 32'h0;
        settle();
        check("hold_2nd_data_ok", 32'(bus.data_data_ok), 1);
        tick();
        bus.rvalid = 0; bus.arready = 0;

        // Reset while RADDR is waiting on arready
        req(1'b0, 2'b10, 32'h0000_2000, 32'h0);
        tick();
        bus.data_req = 0;
        settle();
        check("rs_arvalid_pre", 32'(bus.arvalid), 1);
        rst = 1;
        tick();
        rst = 0;
        settle();
        check("rs_arvalid",  32'(bus.arvalid), 0);
        check("rs_rready",   32'(bus.rready), 0);
        check("rs_awvalid",  32'(bus.awvalid), 0);
        check("rs_wvalid",   32'(bus.wvalid), 0);
        req(1'b0, 2'b10, 32'h0000_3004, 32'h0);
        bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D;
        settle();
        check("rs_idle_addr_ok", 32'(bus.data_addr_ok), 1);
        tick();
        bus.data_req = 0;
        settle();
        check("rs_araddr", bus.araddr, 32'h0000_3004);
        tick();
        settle();
        check("rs_data_ok", 32'(bus.data_data_ok), 1);
        check("rs_rdata",   bus.data_rdata, 32'hCAFE_F00D);
        tick();
        bus.arready = 0; bus.rvalid = 0;

        // Back-to-back write then read, data_req held throughout
        req(1'b1, 2'b10, 32'h0000_4000, 32'h1111_2222);
        bus.awready = 1; bus.wready = 1;
        settle();
        check("bb_c0_addr_ok", 32'(bus.data_addr_ok), 1);
        tick();
        req(1'b0, 2'b10, 32'h0000_5008, 32'h0);
        settle();
        check("bb_c1_awvalid", 32'(bus.awvalid), 1);
        check("bb_c1_addr_ok", 32'(bus.data_addr_ok), 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            settle();
            check("bb_wait_bready",  32'(bus.bready), 1);
            check("bb_wait_arvalid", 32'(bus.arvalid), 0);
            check("bb_wait_addr_ok", 32'(bus.data_addr_ok), 0);
            tick();
        end
        bus.bvalid = 1;
        settle();
        check("bb_b_data_ok", 32'(bus.data_data_ok), 1);
        check("bb_b_addr_ok", 32'(bus.data_addr_ok), 0);
        check("bb_b_arvalid", 32'(bus.arvalid), 0);
        tick();
        bus.bvalid = 0; bus.awready = 0; bus.wready = 0;
        bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'h0BAD_CAFE;
        settle();
        check("bb_rd_addr_ok", 32'(bus.data_addr_ok), 1);
        check("bb_rd_data_ok", 32'(bus.data_data_ok), 0);
        tick();
        bus.data_req = 0;
        settle();
        check("bb_rd_arvalid", 32'(bus.arvalid), 1);
        check("bb_rd_araddr",  bus.araddr, 32'h0000_5008);
        tick();
        settle();
        check("bb_rd_done",  32'(bus.data_data_ok), 1);
        check("bb_rd_rdata", bus.data_rdata, 32'h0BAD_CAFE);
        tick();
        bus.arready = 0; bus.rvalid = 0;
        settle();
        check("bb_end_idle", 32'(bus.data_data_ok), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
